// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read port, almost-empty/full flags,
// hysteretic pause and error flag. Define FIFO_STICKY_ERR_EN to make err_fifo sticky until reset.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_wr,
    input  logic                  fifo_rd,
    input  logic [ADDR_WIDTH:0]   al_empty_in,
    input  logic [ADDR_WIDTH:0]   al_full_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  al_empty,
    output logic                  al_full,
    output logic                  pause,
    output logic                  err_fifo,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  err_evt;
    logic [ADDR_WIDTH:0]   count_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign al_empty   = (count <= al_empty_in);
    assign al_full    = (count >= al_full_in);

    // A write into a full FIFO is only legal when a read frees a slot on the same edge.
    assign rd_ok   = fifo_rd & ~fifo_empty;
    assign wr_ok   = fifo_wr & (~fifo_full | rd_ok);
    assign err_evt = (fifo_wr & fifo_full & ~rd_ok) | (fifo_rd & fifo_empty);

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok)
            count_next = count + (ADDR_WIDTH + 1)'(1);
        else if (rd_ok && !wr_ok)
            count_next = count - (ADDR_WIDTH + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            pause     <= 1'b0;
            err_fifo  <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out <= rd_ok;
            count     <= count_next;
            // Set wins over clear so overlapping thresholds still assert back-pressure.
            if (count_next >= al_full_in)
                pause <= 1'b1;
            else if (count_next <= al_empty_in)
                pause <= 1'b0;
`ifdef FIFO_STICKY_ERR_EN
            err_fifo <= err_fifo | err_evt;
`else
            err_fifo <= err_evt;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_param;
    localparam int DW = 6;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          RESET_L;
    logic [DW-1:0] data_in;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [AW:0]   al_empty_in;
    logic [AW:0]   al_full_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          al_empty;
    logic          al_full;
    logic          pause;
    logic          err_fifo;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .RESET_L(RESET_L), .data_in(data_in), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .al_empty_in(al_empty_in), .al_full_in(al_full_in), .data_out(data_out),
        .valid_out(valid_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .al_empty(al_empty), .al_full(al_full), .pause(pause), .err_fifo(err_fifo),
        .count(count)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_valid;
    bit            m_pause;
    bit            m_err;
    int            max_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_empty"}, 32'(fifo_empty), 32'(n == 0));
        check({tag, "_full"}, 32'(fifo_full), 32'(n == DEPTH));
        check({tag, "_al_empty"}, 32'(al_empty), 32'(n <= int'(al_empty_in)));
        check({tag, "_al_full"}, 32'(al_full), 32'(n >= int'(al_full_in)));
        check({tag, "_valid"}, 32'(valid_out), 32'(m_valid));
        check({tag, "_dout"}, 32'(data_out), 32'(m_dout));
        check({tag, "_pause"}, 32'(pause), 32'(m_pause));
        check({tag, "_err"}, 32'(err_fifo), 32'(m_err));
    endtask

    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] din, input string tag);
        int  n;
        bit  rd_acc, wr_acc, err_evt;
        fifo_wr = wr;
        fifo_rd = rd;
        data_in = din;
        n = q.size();
        rd_acc  = rd && (n > 0);
        wr_acc  = wr && ((n < DEPTH) || rd_acc);
        err_evt = (wr && (n == DEPTH) && !rd_acc) || (rd && (n == 0));
        @(posedge clk);
        #1;
        if (rd_acc) m_dout = q.pop_front();
        m_valid = rd_acc;
        if (wr_acc) q.push_back(din);
        if (q.size() >= int'(al_full_in)) m_pause = 1'b1;
        else if (q.size() <= int'(al_empty_in)) m_pause = 1'b0;
`ifdef FIFO_STICKY_ERR_EN
        m_err = m_err | err_evt;
`else
        m_err = err_evt;
`endif
        if (q.size() > max_count) max_count = q.size();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        RESET_L = 1'b0;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        @(posedge clk);
        #1;
        RESET_L = 1'b1;
        q.delete();
        m_dout = '0;
        m_valid = 1'b0;
        m_pause = 1'b0;
        m_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        RESET_L = 1'b0;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        data_in = '0;
        al_empty_in = 4'd1;
        al_full_in = 4'd7;
        max_count = 0;

        // Reset state
        do_reset("reset");
        check("reset_empty_const", 32'(fifo_empty), 32'd1);
        check("reset_count_const", 32'(count), 32'd0);

        // Fill then drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i), "fill");
        check("fill_count8", 32'(count), 32'd8);
        check("fill_full", 32'(fifo_full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            check("drain_order", 32'(data_out), 32'(i));
            check("drain_valid", 32'(valid_out), 32'd1);
        end
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // Overflow and underflow errors
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i + 16), "fill2");
        step(1'b1, 1'b0, 6'h3F, "overflow");
        check("overflow_err", 32'(err_fifo), 32'd1);
        check("overflow_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "drain2");
        step(1'b0, 1'b1, '0, "underflow");
        check("underflow_err", 32'(err_fifo), 32'd1);
        check("underflow_valid", 32'(valid_out), 32'd0);

        // Simultaneous write and read while full
        do_reset("reset2");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i + 1), "fill3");
        step(1'b1, 1'b1, 6'h2A, "full_rw");
        check("full_rw_count", 32'(count), 32'd8);
        check("full_rw_err", 32'(err_fifo), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "drain3");
        check("full_rw_last", 32'(data_out), 32'h2A);

        // Pause hysteresis
        do_reset("reset3");
        al_full_in = 4'd6;
        al_empty_in = 4'd2;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom), "pfill");
        check("pause_set", 32'(pause), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "pdrain");
        check("pause_hold3", 32'(pause), 32'd1);
        step(1'b0, 1'b1, '0, "pdrain2");
        check("pause_clear2", 32'(pause), 32'd0);

        // Pointer wrap with write/read pairs
        do_reset("reset4");
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, DW'(i + 5), "wrap_wr");
            step(1'b0, 1'b1, '0, "wrap_rd");
            check("wrap_data", 32'(data_out), 32'(DW'(i + 5)));
        end
        check("wrap_max_count", 32'(max_count), 32'd1);

        // Mid-operation reset
        al_full_in = 4'd4;
        step(1'b0, 1'b1, '0, "pre_err");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(i), "pre_rst");
        check("pre_rst_pause", 32'(pause), 32'd1);
        do_reset("midreset");
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_pause", 32'(pause), 32'd0);
        check("midreset_err", 32'(err_fifo), 32'd0);

        // Randomized traffic with shifting bias and thresholds
        for (int seg = 0; seg < 15; seg++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            al_empty_in = AW'($urandom_range(0, 10));
            al_full_in = AW'($urandom_range(0, 10));
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 599) == 0) do_reset("rand_rst");
                else step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
